// File: rtl/bft_out_arbiter.sv
// Credit-throttled round-robin arbiter that packs user output words onto one BFT link.
// Each accepted word becomes {valid, dest leaf, dest port, seq, payload}, registered one cycle after its ack.
module bft_out_arbiter #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_OUT_PORTS      = 4,
  parameter int NUM_BRAM_ADDR_BITS = 7
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2arb,
  output logic [NUM_OUT_PORTS-1:0]              ack_arb2user,
  output logic [PACKET_BITS-1:0]                dout_arb2bft,
  input  logic                                  resend,
  input  logic                                  cred_vld,
  input  logic [2:0]                            cred_port,
  input  logic [NUM_BRAM_ADDR_BITS:0]           cred_amt,
  input  logic                                  cfg_we,
  input  logic [2:0]                            cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport
);

  localparam int PTR_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_W = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CRED_W-1:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

  // Handshake: a word transfers on port i in any cycle where vld_user2arb[i] and
  // ack_arb2user[i] are both high; ack never rises without vld and is at most one-hot.

  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq       [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit    [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_nxt[NUM_OUT_PORTS];
  logic [CRED_W:0]          credit_sum[NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic                     gnt_vld;
  logic [PTR_W-1:0]         gnt_idx;
  int                       srch_idx;
  logic [PACKET_BITS-1:0]   pkt_d;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      elig[i] = reset_n && !resend && vld_user2arb[i] && (credit[i] != '0);
  end

  // Search starting at rr so the most recently served port goes to the back of the line.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      srch_idx = (int'(rr) + k) % NUM_OUT_PORTS;
      if (!gnt_vld && elig[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(srch_idx);
      end
    end
  end

  always_comb begin
    ack_arb2user = '0;
    if (gnt_vld) ack_arb2user[gnt_idx] = 1'b1;
  end

  always_comb begin
    pkt_d = '0;
    if (gnt_vld)
      pkt_d = {1'b1, dest_leaf[gnt_idx], dest_port[gnt_idx], seq[gnt_idx],
               din_user2arb[int'(gnt_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]};
  end

  // One guard bit above the credit width holds the pre-saturation sum.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = {1'b0, credit[i]};
      if (cred_vld && int'(cred_port) == i)
        credit_sum[i] = credit_sum[i] + {1'b0, cred_amt};
      if (gnt_vld && int'(gnt_idx) == i)
        credit_sum[i] = credit_sum[i] - (CRED_W+1)'(1);
      credit_nxt[i] = (credit_sum[i] > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                            : credit_sum[i][CRED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr           <= '0;
      dout_arb2bft <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        seq[i]       <= '0;
        credit[i]    <= CREDIT_MAX;
      end
    end else begin
      dout_arb2bft <= pkt_d;
      if (gnt_vld)
        rr <= (int'(gnt_idx) == NUM_OUT_PORTS - 1) ? '0 : gnt_idx + PTR_W'(1);
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (gnt_vld && int'(gnt_idx) == i)
          seq[i] <= seq[i] + NUM_ADDR_BITS'(1);
        if (cfg_we && int'(cfg_port) == i) begin
          dest_leaf[i] <= cfg_leaf;
          dest_port[i] <= cfg_dport;
        end
      end
    end
  end

endmodule

// File: tb/tb_bft_out_arbiter.sv
// Directed bench for bft_out_arbiter: arbitration order, credits, saturation, seq wrap, config, resend, reset.
module tb_bft_out_arbiter;

  localparam int N = 4;
  localparam int P = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*P-1:0] din_user2arb;
  logic [N-1:0]   vld_user2arb;
  logic [N-1:0]   ack_arb2user;
  logic [48:0]    dout_arb2bft;
  logic           resend;
  logic           cred_vld;
  logic [2:0]     cred_port;
  logic [7:0]     cred_amt;
  logic           cfg_we;
  logic [2:0]     cfg_port;
  logic [4:0]     cfg_leaf;
  logic [3:0]     cfg_dport;

  int n_checks = 0;
  int n_pass   = 0;
  int acks;
  int sq [N];
  int ord [8] = '{0, 1, 2, 3, 0, 2, 3, 0};

  bft_out_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din_user2arb (din_user2arb),
    .vld_user2arb (vld_user2arb),
    .ack_arb2user (ack_arb2user),
    .dout_arb2bft (dout_arb2bft),
    .resend       (resend),
    .cred_vld     (cred_vld),
    .cred_port    (cred_port),
    .cred_amt     (cred_amt),
    .cfg_we       (cfg_we),
    .cfg_port     (cfg_port),
    .cfg_leaf     (cfg_leaf),
    .cfg_dport    (cfg_dport)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [48:0] pkt(input int leaf, input int port, input int sqv,
                                      input logic [31:0] pay);
    return {1'b1, 5'(leaf), 4'(port), 7'(sqv), pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    din_user2arb = '0;
    vld_user2arb = '0;
    resend       = 1'b0;
    cred_vld     = 1'b0;
    cred_port    = '0;
    cred_amt     = '0;
    cfg_we       = 1'b0;
    cfg_port     = '0;
    cfg_leaf     = '0;
    cfg_dport    = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    reset_n      = 1'b0;
    vld_user2arb = 4'b1111;
    tick();
    check("rst_ack", 64'(ack_arb2user), 64'h0);
    check("rst_dout", 64'(dout_arb2bft), 64'h0);
    do_reset();

    // single port stream on default destination
    vld_user2arb = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      din_user2arb[31:0] = 32'hA000_0000 + 32'(k);
      #1;
      check("t1_ack", 64'(ack_arb2user), 64'h1);
      tick();
      check("t1_pkt", 64'(dout_arb2bft), 64'(pkt(0, 0, k, 32'hA000_0000 + 32'(k))));
    end
    vld_user2arb = '0;
    tick();
    check("t1_idle", 64'(dout_arb2bft), 64'h0);

    // round robin, then port 1 drops out
    do_reset();
    for (int i = 0; i < N; i++) begin
      din_user2arb[i*P +: P] = 32'hB0 + 32'(i);
      sq[i] = 0;
    end
    for (int j = 0; j < 8; j++) begin
      vld_user2arb = (j < 4) ? 4'b1111 : 4'b1101;
      #1;
      check("t2_ack", 64'(ack_arb2user), 64'(4'b0001 << ord[j]));
      tick();
      check("t2_pkt", 64'(dout_arb2bft), 64'(pkt(0, 0, sq[ord[j]], 32'hB0 + 32'(ord[j]))));
      sq[ord[j]]++;
    end

    // credit exhaustion on port 2, bad-port return ignored, return of 5
    do_reset();
    vld_user2arb = 4'b0100;
    acks = 0;
    for (int k = 0; k < 129; k++) begin
      #1;
      if (ack_arb2user[2]) acks++;
      tick();
    end
    check("t3_cnt128", 64'(acks), 64'd128);
    #1;
    check("t3_empty", 64'(ack_arb2user), 64'h0);
    cred_vld = 1'b1; cred_port = 3'd6; cred_amt = 8'd5;
    tick();
    cred_vld = 1'b0;
    #1;
    check("t3_badport", 64'(ack_arb2user), 64'h0);
    cred_vld = 1'b1; cred_port = 3'd2; cred_amt = 8'd5;
    #1;
    check("t3_ret_cycle", 64'(ack_arb2user), 64'h0);
    tick();
    cred_vld = 1'b0;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (ack_arb2user[2]) acks++;
      tick();
    end
    check("t3_cnt5", 64'(acks), 64'd5);

    // saturation: grant + return 10 at credit 127 leaves 128
    do_reset();
    vld_user2arb = 4'b1000;
    #1;
    check("t4_ack0", 64'(ack_arb2user), 64'h8);
    tick();
    cred_vld = 1'b1; cred_port = 3'd3; cred_amt = 8'd10;
    #1;
    check("t4_ack1", 64'(ack_arb2user), 64'h8);
    tick();
    cred_vld = 1'b0;
    acks = 0;
    for (int k = 0; k < 130; k++) begin
      #1;
      if (ack_arb2user[3]) acks++;
      tick();
    end
    check("t4_sat", 64'(acks), 64'd128);

    // config port 1, stream 130 words with credit returns, seq wraps
    do_reset();
    cfg_we = 1'b1; cfg_port = 3'd1; cfg_leaf = 5'd17; cfg_dport = 4'd9;
    tick();
    cfg_we = 1'b0;
    vld_user2arb = 4'b0010;
    cred_vld = 1'b1; cred_port = 3'd1; cred_amt = 8'd1;
    for (int k = 0; k < 130; k++) begin
      din_user2arb[P +: P] = 32'hC000_0000 + 32'(k);
      #1;
      check("t5_ack", 64'(ack_arb2user), 64'h2);
      tick();
      check("t5_pkt", 64'(dout_arb2bft), 64'(pkt(17, 9, k % 128, 32'hC000_0000 + 32'(k))));
    end
    cfg_we = 1'b1; cfg_port = 3'd1; cfg_leaf = 5'd3; cfg_dport = 4'd2;
    din_user2arb[P +: P] = 32'hD0;
    tick();
    cfg_we = 1'b0;
    check("t5_cfg_old", 64'(dout_arb2bft), 64'(pkt(17, 9, 2, 32'hD0)));
    din_user2arb[P +: P] = 32'hD1;
    tick();
    check("t5_cfg_new", 64'(dout_arb2bft), 64'(pkt(3, 2, 3, 32'hD1)));

    // resend pulse mid-stream
    resend = 1'b1;
    #1;
    check("t6_ack_a", 64'(ack_arb2user), 64'h0);
    tick();
    check("t6_dout_a", 64'(dout_arb2bft), 64'h0);
    #1;
    check("t6_ack_b", 64'(ack_arb2user), 64'h0);
    tick();
    check("t6_dout_b", 64'(dout_arb2bft), 64'h0);
    resend = 1'b0;
    din_user2arb[P +: P] = 32'hE0;
    #1;
    check("t6_ack_resume", 64'(ack_arb2user), 64'h2);
    tick();
    check("t6_pkt_resume", 64'(dout_arb2bft), 64'(pkt(3, 2, 4, 32'hE0)));
    din_user2arb[P +: P] = 32'hF0;
    tick();
    check("t7_pkt", 64'(dout_arb2bft), 64'(pkt(3, 2, 5, 32'hF0)));

    // asynchronous reset drops the registered packet immediately
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_dout", 64'(dout_arb2bft), 64'h0);
    check("t7_rst_ack", 64'(ack_arb2user), 64'h0);
    tick();
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
